// File: rtl/ysyx_25060170_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory handshake, decode handoff,
// writeback commit and status. The fetch unit holds the master side. The
// memory/decode/writeback environment holds the slave side.
interface ysyx_25060170_fetch_unit_if;

  // Instruction memory channel
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  // Decode handoff
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  // Writeback commit
  logic        commit_valid_i;
  logic [31:0] npc_i;

  // Status
  logic        fetch_err_o;
  logic [31:0] fetch_cnt_o;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i,
    input  mem_err_i,
    output inst_valid_o,
    input  inst_ready_i,
    output pc_o,
    output inst_o,
    input  commit_valid_i,
    input  npc_i,
    output fetch_err_o,
    output fetch_cnt_o
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i,
    output mem_err_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  pc_o,
    input  inst_o,
    output commit_valid_i,
    output npc_i,
    input  fetch_err_o,
    input  fetch_cnt_o
  );

endinterface

// File: rtl/ysyx_25060170_fetch_unit.sv
// Single-issue instruction fetch unit for a multi-cycle core.
// The unit fetches one instruction and hands it to decode. It then waits
// for writeback to commit that instruction and supply the next PC. At most
// one memory request is ever outstanding. A memory error or a misaligned
// next PC parks the unit in ERR until reset.
module ysyx_25060170_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  ysyx_25060170_fetch_unit_if.master      bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DELIV = 3'd3,
    ST_EXEC  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] fetch_cnt_q;
  logic        fetch_err_q;
  logic        mem_req_q;
  logic        inst_valid_q;

  // Control FSM and datapath registers. Each output is a flop. Each flop is
  // updated together with the state transition that needs it, so no input
  // reaches an output combinationally.
  always_ff @(posedge clk) begin
    // NOTE: every register here is sequential state, so it uses non-blocking
    // assignment only. Later statements then see pre-edge values.
    if (!rst_n) begin
      // NOTE: the reset is synchronous and clears every register. This
      // includes the instruction latch, so decode never sees a stale word
      // after reset.
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      fetch_cnt_q  <= '0;
      fetch_err_q  <= 1'b0;
      mem_req_q    <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q   <= ST_REQ;
          mem_req_q <= 1'b1;
        end

        // Request and address are held until memory grants. A response in
        // the same cycle as the grant is not looked at here.
        ST_REQ: begin
          if (bus.mem_gnt_i) begin
            state_q   <= ST_WAIT;
            mem_req_q <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (bus.mem_rvalid_i) begin
            if (bus.mem_err_i) begin
              state_q     <= ST_ERR;
              fetch_err_q <= 1'b1;
            end else begin
              state_q      <= ST_DELIV;
              inst_q       <= bus.mem_rdata_i;
              inst_valid_q <= 1'b1;
            end
          end
        end

        // pc_q and inst_q do not change in this state, so the word offered
        // to decode stays stable under backpressure.
        ST_DELIV: begin
          if (bus.inst_ready_i) begin
            state_q      <= ST_EXEC;
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= fetch_cnt_q + 32'd1;
          end
        end

        // The next PC is taken only here. Commits seen in any other state
        // are dropped.
        ST_EXEC: begin
          if (bus.commit_valid_i) begin
            pc_q <= bus.npc_i;
            if (bus.npc_i[1:0] == 2'b00) begin
              state_q   <= ST_REQ;
              mem_req_q <= 1'b1;
            end else begin
              state_q     <= ST_ERR;
              fetch_err_q <= 1'b1;
            end
          end
        end

        ST_ERR: begin
          state_q      <= ST_ERR;
          mem_req_q    <= 1'b0;
          inst_valid_q <= 1'b0;
          fetch_err_q  <= 1'b1;
        end

        default: begin
          state_q      <= ST_IDLE;
          mem_req_q    <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Drive the bus from the registers.
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_addr_o   = pc_q;
  assign bus.inst_valid_o = inst_valid_q;
  assign bus.pc_o         = pc_q;
  assign bus.inst_o       = inst_q;
  assign bus.fetch_err_o  = fetch_err_q;
  assign bus.fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: doc/ysyx_25060170_fetch_unit.md
YSYX_25060170_FETCH_UNIT -- requirements
Module: ysyx_25060170_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC loaded on reset.
REQ-002 SHALL use one clock and a synchronous, active-low reset.
REQ-003 SHALL have ports:
  clk  input  1  sole clock, rising edge.
  rst_n  input  1  synchronous active-low reset.
  mem_req_o  output  1  fetch request to instruction memory.
  mem_addr_o  output  32  fetch address, equal to the current PC.
  mem_gnt_i  input  1  memory accepts the request.
  mem_rvalid_i  input  1  read response valid.
  mem_rdata_i  input  32  instruction word.
  mem_err_i  input  1  response error, qualified by mem_rvalid_i.
  inst_valid_o  output  1  instruction available to the decode stage.
  inst_ready_i  input  1  decode stage accepts the instruction.
  pc_o  output  32  PC of the delivered instruction.
  inst_o  output  32  delivered instruction.
  commit_valid_i  input  1  writeback has completed the current instruction.
  npc_i  input  32  next PC from writeback: PC+4, or the jal/jalr target.
  fetch_err_o  output  1  sticky fetch fault.
  fetch_cnt_o  output  32  count of delivered instructions.

Function
REQ-004 SHALL implement FSM states IDLE, REQ, WAIT, DELIV, EXEC, ERR; all outputs SHALL be registered or decoded from state and registers only, with no input-to-output combinational path.
REQ-005 IDLE: mem_req_o=0; SHALL go to REQ unconditionally on the next edge.
REQ-006 REQ: mem_req_o=1 and mem_addr_o=PC, both held stable until mem_gnt_i; on mem_gnt_i SHALL go to WAIT.
REQ-007 WAIT: mem_req_o=0.
  - mem_rvalid_i & !mem_err_i: latch mem_rdata_i into inst_o, go to DELIV.
  - mem_rvalid_i & mem_err_i: go to ERR.
REQ-008 mem_rvalid_i in any state other than WAIT SHALL be ignored, including a response in the same cycle as the grant.
REQ-009 DELIV: inst_valid_o=1; pc_o and inst_o SHALL stay stable until inst_ready_i is high; on inst_valid_o & inst_ready_i, increment fetch_cnt_o and go to EXEC.
REQ-010 EXEC: inst_valid_o=0; on commit_valid_i, load PC<=npc_i.
  - npc_i[1:0]==0: go to REQ.
  - otherwise: go to ERR.
REQ-011 commit_valid_i outside EXEC SHALL be ignored and SHALL NOT change the PC.
REQ-012 ERR: mem_req_o=0, inst_valid_o=0, fetch_err_o=1; the state is held until reset.
REQ-013 pc_o SHALL equal the PC register at all times; mem_addr_o SHALL equal the PC register.
REQ-014 fetch_cnt_o SHALL wrap from 32'hFFFF_FFFF to 0 without any flag.
REQ-015 Minimum loop latency, with gnt in the first REQ cycle, rvalid the cycle after, and ready and commit immediate: REQ->WAIT->DELIV->EXEC->REQ = 4 cycles per instruction.
REQ-016 Each instruction SHALL be fetched exactly once, with at most one outstanding memory request.

Reset
REQ-017 Whenever rst_n=0 at a rising edge, SHALL set:
  - state=IDLE, PC=RESET_PC.
  - inst_o=0, fetch_cnt_o=0, fetch_err_o=0.
  - mem_req_o=0, inst_valid_o=0.
REQ-018 Reset asserted mid-transaction (in REQ, WAIT, DELIV or EXEC) SHALL abandon the transaction; instruction memory is reset by the same rst_n, so no stale response survives reset.
REQ-019 Reset SHALL clear ERR.

Verification
REQ-020 Reset release: mem_req_o rises 1 cycle after IDLE with mem_addr_o=32'h8000_0000; fetch_cnt_o=0.
REQ-021 Straight line: memory returns 0x00000413 with gnt immediate and rvalid +1; ready=1; commit npc=0x80000004 -> next mem_addr_o=0x80000004, fetch_cnt_o=1, 4 cycles between requests.
REQ-022 Backpressure and gnt delay: gnt held low 3 cycles, inst_ready_i low 5 cycles -> mem_addr_o, pc_o and inst_o stable throughout, inst_valid_o stays high, exactly one count increment.
REQ-023 Jump: commit npc_i=0x80000100 -> next request at 0x80000100; commit_valid_i pulsed during DELIV is ignored.
REQ-024 Faults, each from a fresh reset:
  - rvalid with mem_err_i=1 -> fetch_err_o=1 and no further requests.
  - npc_i=0x80000102 -> ERR.
  - Both are cleared by rst_n=0.
REQ-025 Wrap: fetch_cnt_o forced to 32'hFFFF_FFFF, one delivery -> 0.
